// File: rtl/branch_ctrl_ras_if.sv
// Branch/jump control bundle: decode operands and ALU flags in, registered PC redirect and RAS status out.
// Latency: transport only; the slave side registers its outputs 1 cycle after an accepted opcode.
// Backpressure: none on this bundle; the producer holds the slave frozen with stall.
// Ports: enable/valid_in/stall qualify an opcode; opcode/pc/target/zero/negative carry it;
//        valid_out/jump/target_out/ras_* return the result. Build macro BRANCH_STATS_EN adds taken_cnt/nottaken_cnt.
interface branch_ctrl_ras_if #(
    parameter int ADDR_W = 12
`ifdef BRANCH_STATS_EN
    , parameter int CNT_W = 16
`endif
);
    logic              enable;
    logic              valid_in;
    logic              stall;
    logic [5:0]        opcode;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] target;
    logic              zero;
    logic              negative;
    logic              valid_out;
    logic              jump;
    logic [ADDR_W-1:0] target_out;
    logic              ras_empty;
    logic              ras_full;
    logic              ras_underflow;
`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0]  taken_cnt;
    logic [CNT_W-1:0]  nottaken_cnt;

    modport master (
        output enable, valid_in, stall, opcode, pc, target, zero, negative,
        input  valid_out, jump, target_out, ras_empty, ras_full, ras_underflow,
        input  taken_cnt, nottaken_cnt
    );
    modport slave (
        input  enable, valid_in, stall, opcode, pc, target, zero, negative,
        output valid_out, jump, target_out, ras_empty, ras_full, ras_underflow,
        output taken_cnt, nottaken_cnt
    );
`else
    modport master (
        output enable, valid_in, stall, opcode, pc, target, zero, negative,
        input  valid_out, jump, target_out, ras_empty, ras_full, ras_underflow
    );
    modport slave (
        input  enable, valid_in, stall, opcode, pc, target, zero, negative,
        output valid_out, jump, target_out, ras_empty, ras_full, ras_underflow
    );
`endif
endinterface

// File: rtl/branch_ctrl_ras.sv
// Resolves beq/bneq/blz/jmp/jmpr/jal into a registered PC redirect, with a circular return-address stack.
// Latency: 1 cycle from an accepted opcode (enable & valid_in & !stall) to valid_out/jump/target_out.
// Backpressure: stall freezes every register, the RAS and the counters; stall beats all other inputs.
// Ports: clock, reset_n (async, active low); bus (branch_ctrl_ras_if.slave) carries operands and results.
// Optional: define BRANCH_STATS_EN to add saturating taken_cnt/nottaken_cnt statistics.
module branch_ctrl_ras #(
    parameter int ADDR_W    = 12,
    parameter int RAS_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    branch_ctrl_ras_if.slave  bus
);
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_RAS_W = PTR_W + 1;

    localparam logic [5:0] OP_BEQ  = 6'b001111;
    localparam logic [5:0] OP_BNEQ = 6'b010000;
    localparam logic [5:0] OP_BLZ  = 6'b010001;
    localparam logic [5:0] OP_JMP  = 6'b001101;
    localparam logic [5:0] OP_JMPR = 6'b001110;
    localparam logic [5:0] OP_JAL  = 6'b011010;

    // Pointer wrap relies on the depth being a power of two.
    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0 || CNT_W < 1) begin : g_param_chk
        $error("branch_ctrl_ras: RAS_DEPTH must be a power of two >= 2 and CNT_W >= 1");
    end

    logic [ADDR_W-1:0]    ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]     ras_ptr;      // next free slot; top entry sits at ras_ptr-1
    logic [CNT_RAS_W-1:0] ras_cnt;

    logic                 valid_q;
    logic                 jump_q;
    logic [ADDR_W-1:0]    target_q;
    logic                 underflow_q;

    logic                 accept;
    logic                 jump_nxt;
    logic [ADDR_W-1:0]    target_nxt;
    logic                 underflow_nxt;
    logic                 push;
    logic                 pop;
    logic                 is_cond;
    logic [PTR_W-1:0]     ptr_dec;
    logic                 ras_is_empty;
    logic                 ras_is_full;

    assign accept       = bus.enable & bus.valid_in & ~bus.stall;
    assign ptr_dec      = ras_ptr - PTR_W'(1);
    assign ras_is_empty = (ras_cnt == '0);
    assign ras_is_full  = (ras_cnt == CNT_RAS_W'(RAS_DEPTH));

    // Resolution of the current opcode; push/pop are only honoured when accept is high.
    always_comb begin
        jump_nxt      = 1'b0;
        target_nxt    = bus.pc;
        underflow_nxt = 1'b0;
        push          = 1'b0;
        pop           = 1'b0;
        is_cond       = 1'b0;
        case (bus.opcode)
            OP_BEQ: begin
                is_cond = 1'b1;
                if (bus.zero) begin
                    jump_nxt   = 1'b1;
                    target_nxt = bus.pc + bus.target;
                end
            end
            OP_BNEQ: begin
                is_cond = 1'b1;
                if (!bus.zero) begin
                    jump_nxt   = 1'b1;
                    target_nxt = bus.target;
                end
            end
            OP_BLZ: begin
                is_cond = 1'b1;
                if (bus.negative) begin
                    jump_nxt   = 1'b1;
                    target_nxt = bus.pc + bus.target;
                end
            end
            OP_JMP: begin
                jump_nxt   = 1'b1;
                target_nxt = bus.target;
            end
            OP_JAL: begin
                jump_nxt   = 1'b1;
                target_nxt = bus.target;
                push       = 1'b1;
            end
            OP_JMPR: begin
                jump_nxt = 1'b1;
                if (!ras_is_empty) begin
                    pop        = 1'b1;
                    target_nxt = ras_mem[ptr_dec];
                end else begin
                    // Empty stack falls back to the link-style target+1 and flags it.
                    target_nxt    = bus.target + ADDR_W'(1);
                    underflow_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q     <= 1'b0;
            jump_q      <= 1'b0;
            target_q    <= '0;
            underflow_q <= 1'b0;
            ras_ptr     <= '0;
            ras_cnt     <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
        end else if (!bus.stall) begin
            if (accept) begin
                valid_q     <= 1'b1;
                jump_q      <= jump_nxt;
                target_q    <= target_nxt;
                underflow_q <= underflow_nxt;
                if (push) begin
                    // When full the write lands on the oldest entry and the count saturates.
                    ras_mem[ras_ptr] <= bus.pc + ADDR_W'(1);
                    ras_ptr          <= ras_ptr + PTR_W'(1);
                    if (!ras_is_full) ras_cnt <= ras_cnt + CNT_RAS_W'(1);
                end else if (pop) begin
                    ras_ptr <= ptr_dec;
                    ras_cnt <= ras_cnt - CNT_RAS_W'(1);
                end
            end else begin
                valid_q     <= 1'b0;
                jump_q      <= 1'b0;
                target_q    <= '0;
                underflow_q <= 1'b0;
            end
        end
    end

    assign bus.valid_out     = valid_q;
    assign bus.jump          = jump_q;
    assign bus.target_out    = target_q;
    assign bus.ras_underflow = underflow_q;
    assign bus.ras_empty     = ras_is_empty;
    assign bus.ras_full      = ras_is_full;

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] taken_q;
    logic [CNT_W-1:0] nottaken_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            taken_q    <= '0;
            nottaken_q <= '0;
        end else if (accept) begin
            if (jump_nxt && taken_q != '1) taken_q <= taken_q + CNT_W'(1);
            if (is_cond && !jump_nxt && nottaken_q != '1) nottaken_q <= nottaken_q + CNT_W'(1);
        end
    end

    assign bus.taken_cnt    = taken_q;
    assign bus.nottaken_cnt = nottaken_q;
`endif
endmodule

// File: tb/tb_branch_ctrl_ras.sv
// Self-checking bench for branch_ctrl_ras: directed table, multi-cycle RAS/stall/reset sequences, random run.
// Latency: expects results 1 cycle after each driven opcode, sampled 1 time unit after the rising edge.
// Backpressure: exercises stall freezing and asynchronous reset while stalled.
module tb_branch_ctrl_ras;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 16;

    localparam logic [5:0] BEQ  = 6'b001111;
    localparam logic [5:0] BNEQ = 6'b010000;
    localparam logic [5:0] BLZ  = 6'b010001;
    localparam logic [5:0] JMP  = 6'b001101;
    localparam logic [5:0] JMPR = 6'b001110;
    localparam logic [5:0] JAL  = 6'b011010;
    localparam logic [5:0] BAD  = 6'b111111;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

`ifdef BRANCH_STATS_EN
    branch_ctrl_ras_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();
`else
    branch_ctrl_ras_if #(.ADDR_W(ADDR_W)) bus ();
`endif

    branch_ctrl_ras #(.ADDR_W(ADDR_W), .RAS_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state: the RAS is a plain queue, newest at the back.
    logic [ADDR_W-1:0] ras_q [$];
    logic              m_valid = 0, m_jump = 0, m_unf = 0;
    logic [ADDR_W-1:0] m_tgt = '0;
    int                m_taken = 0, m_nt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ras_q.delete();
        m_valid = 0; m_jump = 0; m_unf = 0; m_tgt = '0;
        m_taken = 0; m_nt = 0;
    endtask

    task automatic model_step(input logic en, vin, stl, input logic [5:0] op,
                              input logic [ADDR_W-1:0] p, t, input logic z, n);
        bit cond;
        if (stl) return;
        if (!(en && vin)) begin
            m_valid = 0; m_jump = 0; m_tgt = '0; m_unf = 0;
            return;
        end
        m_valid = 1; m_unf = 0; m_jump = 0; m_tgt = p; cond = 0;
        case (op)
            BEQ:  begin cond = 1; if (z)  begin m_jump = 1; m_tgt = p + t; end end
            BNEQ: begin cond = 1; if (!z) begin m_jump = 1; m_tgt = t; end end
            BLZ:  begin cond = 1; if (n)  begin m_jump = 1; m_tgt = p + t; end end
            JMP:  begin m_jump = 1; m_tgt = t; end
            JAL:  begin
                m_jump = 1; m_tgt = t;
                ras_q.push_back(p + 12'd1);
                if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
            end
            JMPR: begin
                m_jump = 1;
                if (ras_q.size() > 0) m_tgt = ras_q.pop_back();
                else begin m_tgt = t + 12'd1; m_unf = 1; end
            end
            default: ;
        endcase
        if (m_jump && m_taken < (1 << CNT_W) - 1) m_taken++;
        if (cond && !m_jump && m_nt < (1 << CNT_W) - 1) m_nt++;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid_out"}, 32'(bus.valid_out), 32'(m_valid));
        chk({tag, ".jump"}, 32'(bus.jump), 32'(m_jump));
        chk({tag, ".target_out"}, 32'(bus.target_out), 32'(m_tgt));
        chk({tag, ".ras_underflow"}, 32'(bus.ras_underflow), 32'(m_unf));
        chk({tag, ".ras_empty"}, 32'(bus.ras_empty), 32'(ras_q.size() == 0));
        chk({tag, ".ras_full"}, 32'(bus.ras_full), 32'(ras_q.size() == DEPTH));
`ifdef BRANCH_STATS_EN
        chk({tag, ".taken_cnt"}, 32'(bus.taken_cnt), 32'(m_taken));
        chk({tag, ".nottaken_cnt"}, 32'(bus.nottaken_cnt), 32'(m_nt));
`endif
    endtask

    // Drive one cycle of inputs, advance the model, then sample after the edge.
    task automatic step(input string tag, input logic en, vin, stl, input logic [5:0] op,
                        input logic [ADDR_W-1:0] p, t, input logic z, n);
        bus.enable = en; bus.valid_in = vin; bus.stall = stl; bus.opcode = op;
        bus.pc = p; bus.target = t; bus.zero = z; bus.negative = n;
        model_step(en, vin, stl, op, p, t, z, n);
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    task automatic op1(input string tag, input logic [5:0] op, input logic [ADDR_W-1:0] p, t,
                       input logic z, n);
        step(tag, 1'b1, 1'b1, 1'b0, op, p, t, z, n);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b1, 1'b0, 1'b0, 6'd0, '0, '0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic [5:0]        op;
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] tgt;
        logic              z;
        logic              n;
        logic              exp_jump;
        logic [ADDR_W-1:0] exp_tgt;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [5:0] ops [7];
        logic [ADDR_W-1:0] exp_pop [4];

        bus.enable = 0; bus.valid_in = 0; bus.stall = 0; bus.opcode = '0;
        bus.pc = '0; bus.target = '0; bus.zero = 0; bus.negative = 0;

        vecs[0] = '{BEQ,  12'h010, 12'h005, 1'b1, 1'b0, 1'b1, 12'h015};
        vecs[1] = '{BEQ,  12'h010, 12'h005, 1'b0, 1'b0, 1'b0, 12'h010};
        vecs[2] = '{BLZ,  12'hFFE, 12'h004, 1'b0, 1'b1, 1'b1, 12'h002};
        vecs[3] = '{BLZ,  12'h0A0, 12'h004, 1'b1, 1'b0, 1'b0, 12'h0A0};
        vecs[4] = '{BNEQ, 12'h050, 12'h123, 1'b0, 1'b0, 1'b1, 12'h123};
        vecs[5] = '{BNEQ, 12'h050, 12'h123, 1'b1, 1'b0, 1'b0, 12'h050};
        vecs[6] = '{JMP,  12'h333, 12'h777, 1'b0, 1'b1, 1'b1, 12'h777};
        vecs[7] = '{BAD,  12'h444, 12'h555, 1'b1, 1'b1, 1'b0, 12'h444};
        vecs[8] = '{6'b000000, 12'h001, 12'h002, 1'b0, 1'b0, 1'b0, 12'h001};
        vecs[9] = '{BEQ,  12'hFFF, 12'h001, 1'b1, 1'b0, 1'b1, 12'h000};

        // Reset state.
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all("reset");
        reset_n = 1'b1;

        // Directed opcode table.
        foreach (vecs[i]) begin
            op1($sformatf("vec%0d", i), vecs[i].op, vecs[i].pc, vecs[i].tgt, vecs[i].z, vecs[i].n);
            chk($sformatf("vec%0d.jump", i), 32'(bus.jump), 32'(vecs[i].exp_jump));
            chk($sformatf("vec%0d.target", i), 32'(bus.target_out), 32'(vecs[i].exp_tgt));
            chk($sformatf("vec%0d.valid", i), 32'(bus.valid_out), 32'd1);
        end
        idle("idle0");
        chk("idle.valid", 32'(bus.valid_out), 32'd0);

        // Call/return nesting.
        op1("jal1", JAL, 12'h100, 12'h200, 0, 0);
        chk("jal1.tgt", 32'(bus.target_out), 32'h200);
        op1("jal2", JAL, 12'h201, 12'h300, 0, 0);
        chk("jal2.tgt", 32'(bus.target_out), 32'h300);
        op1("ret1", JMPR, 12'h000, 12'h000, 0, 0);
        chk("ret1.tgt", 32'(bus.target_out), 32'h202);
        op1("ret2", JMPR, 12'h000, 12'h000, 0, 0);
        chk("ret2.tgt", 32'(bus.target_out), 32'h101);
        chk("ret2.empty", 32'(bus.ras_empty), 32'd1);

        // Underflow pulse lasts one cycle.
        op1("unf", JMPR, 12'h000, 12'h040, 0, 0);
        chk("unf.tgt", 32'(bus.target_out), 32'h041);
        chk("unf.pulse", 32'(bus.ras_underflow), 32'd1);
        idle("unf_idle");
        chk("unf.cleared", 32'(bus.ras_underflow), 32'd0);

        // Overflow: five pushes into four entries drops the oldest.
        for (int i = 1; i <= 5; i++) begin
            op1($sformatf("push%0d", i), JAL, 12'(i), 12'h000, 0, 0);
            if (i == 4) chk("push4.full", 32'(bus.ras_full), 32'd1);
        end
        exp_pop[0] = 12'd6; exp_pop[1] = 12'd5; exp_pop[2] = 12'd4; exp_pop[3] = 12'd3;
        for (int i = 0; i < 4; i++) begin
            op1($sformatf("pop%0d", i), JMPR, 12'h000, 12'h000, 0, 0);
            chk($sformatf("pop%0d.tgt", i), 32'(bus.target_out), 32'(exp_pop[i]));
        end
        chk("pops.empty", 32'(bus.ras_empty), 32'd1);

        // Stall freezes everything, then reset while stalled clears asynchronously.
        op1("pre_stall", JAL, 12'h010, 12'h0AB, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("stall%0d", i), 1'b1, 1'b1, 1'b1, JAL, 12'h700, 12'h0CD, 0, 0);
            chk($sformatf("stall%0d.tgt", i), 32'(bus.target_out), 32'h0AB);
        end
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_mid_stall");
        chk("rst.empty", 32'(bus.ras_empty), 32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        bus.stall = 1'b0;
        idle("post_rst");

`ifdef BRANCH_STATS_EN
        for (int i = 0; i < 3; i++) op1("st_beq", BEQ, 12'h020, 12'h004, 1, 0);
        for (int i = 0; i < 2; i++) op1("st_blz", BLZ, 12'h020, 12'h004, 0, 0);
        chk("stats.taken", 32'(bus.taken_cnt), 32'd3);
        chk("stats.nottaken", 32'(bus.nottaken_cnt), 32'd2);
        op1("st_bad", BAD, 12'h020, 12'h004, 1, 1);
        chk("stats.bad_jump", 32'(bus.jump), 32'd0);
        chk("stats.taken_hold", 32'(bus.taken_cnt), 32'd3);
        chk("stats.nt_hold", 32'(bus.nottaken_cnt), 32'd2);
`endif

        // Random run against the model.
        ops[0] = BEQ; ops[1] = BNEQ; ops[2] = BLZ; ops[3] = JMP;
        ops[4] = JMPR; ops[5] = JAL; ops[6] = BAD;
        for (int i = 0; i < 400; i++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
            step("rand",
                 ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0),
                 op, 12'($urandom), 12'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
